// File: rtl/spi_regfile_periph_if.sv
// SPI pin bundle for spi_regfile_periph.
//   SCLK, nCS, COPI : controller -> peripheral (asynchronous to clk)
//   CIPO, cipo_oe   : peripheral -> controller/pad
// master modport is the SPI controller side, slave modport is the peripheral.
interface spi_regfile_periph_if;
    logic SCLK;
    logic nCS;
    logic COPI;
    logic CIPO;
    logic cipo_oe;

    modport master (output SCLK, output nCS, output COPI, input CIPO, input cipo_oe);
    modport slave  (input SCLK, input nCS, input COPI, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register-file peripheral with read-back on CIPO.
// Frame (MSB first): R/W (1=write) | ADDR_W address bits | DATA_W data bits.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   spi          : SPI pins (slave modport), oversampled in clk domain
//   regs_flat    : register i at [i*DATA_W +: DATA_W]
//   wr_strobe    : one-clk pulse per committed write
//   wr_addr      : address of last committed write
//   frame_abort  : one-clk pulse when nCS rises mid-frame
module spi_regfile_periph #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_regfile_periph_if.slave        spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_abort
);
    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0]  CMD_CNT   = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME);
    localparam logic [ADDR_W:0]   NREGS     = (ADDR_W+1)'(NUM_REGS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // synchronisers (+ previous-value flop for edge detection)
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic ncs_meta_q, ncs_sync_q, ncs_prev_q;
    logic copi_meta_q, copi_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0; sclk_sync_q <= 1'b0; sclk_prev_q <= 1'b0;
            ncs_meta_q  <= 1'b1; ncs_sync_q  <= 1'b1; ncs_prev_q  <= 1'b1;
            copi_meta_q <= 1'b0; copi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi.SCLK; sclk_sync_q <= sclk_meta_q; sclk_prev_q <= sclk_sync_q;
            ncs_meta_q  <= spi.nCS;  ncs_sync_q  <= ncs_meta_q;  ncs_prev_q  <= ncs_sync_q;
            copi_meta_q <= spi.COPI; copi_sync_q <= copi_meta_q;
        end
    end

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign ncs_rise  = ncs_sync_q & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_sync_q & ncs_prev_q;

    logic [1:0]                       state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [FRAME-1:0]                 shift_q, shift_d, shift_nxt;
    logic [DATA_W-1:0]                dout_q, dout_d, rd_val;
    logic                             rd_q, rd_d;
    logic                             cipo_q, cipo_d;
    logic                             done_q, done_d;   // frame completed last cycle
    logic                             abort_q, abort_d;
    logic                             strobe_q, strobe_d;
    logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;

    assign shift_nxt = {shift_q[FRAME-2:0], copi_sync_q};

    // Read mux on the address as it stands once the command is complete;
    // out-of-range addresses match no register and read as 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (shift_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
    end

    // Completed-frame fields, stable in shift_q during the commit cycle
    logic              fr_rw;
    logic [ADDR_W-1:0] fr_addr;
    logic [DATA_W-1:0] fr_data;
    assign fr_rw   = shift_q[FRAME-1];
    assign fr_addr = shift_q[FRAME-2 -: ADDR_W];
    assign fr_data = shift_q[DATA_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        rd_d      = rd_q;
        cipo_d    = cipo_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        regs_d    = regs_q;

        if (done_q && fr_rw && ({1'b0, fr_addr} < NREGS)) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (fr_addr == ADDR_W'(i)) regs_d[i] = fr_data;
            strobe_d  = 1'b1;
            wr_addr_d = fr_addr;
        end

        if (ncs_fall) begin
            // a new frame always restarts, whatever state we were in
            state_d = ST_CMD;
            cnt_d   = '0;
            shift_d = '0;
            rd_d    = 1'b0;
            cipo_d  = 1'b0;
        end else if (ncs_rise) begin
            // an SCLK rise in this same cycle is deliberately dropped
            if (cnt_q != '0 && cnt_q != FRAME_CNT) abort_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
            rd_d    = 1'b0;
            cipo_d  = 1'b0;
        end else if ((state_q == ST_CMD || state_q == ST_DATA) && sclk_rise && !ncs_sync_q) begin
            shift_d = shift_nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            if (state_q == ST_CMD && cnt_d == CMD_CNT) begin
                state_d = ST_DATA;
                rd_d    = ~shift_nxt[ADDR_W];
                dout_d  = shift_nxt[ADDR_W] ? '0 : rd_val;
            end
            if (state_q == ST_DATA && cnt_d == FRAME_CNT) begin
                state_d = ST_DONE;
                rd_d    = 1'b0;
                cipo_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (state_q == ST_DATA && rd_q && sclk_fall && !ncs_sync_q) begin
            cipo_d = dout_q[DATA_W-1];
            dout_d = dout_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            rd_q      <= 1'b0;
            cipo_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            regs_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            rd_q      <= rd_d;
            cipo_q    <= cipo_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            regs_q    <= regs_d;
        end
    end

    assign spi.CIPO    = cipo_q;
    assign spi.cipo_oe = ~ncs_sync_q;
    assign regs_flat   = regs_q;
    assign wr_strobe   = strobe_q;
    assign wr_addr     = wr_addr_q;
    assign frame_abort = abort_q;
endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph (8 regs, 7-bit addr, 8-bit data, SCLK = clk/8).
module tb_spi_regfile_periph;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_regfile_periph_if sif();
    logic [63:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_abort;

    spi_regfile_periph #(.NUM_REGS(8), .ADDR_W(7), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (sif),
        .regs_flat   (regs_flat),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .frame_abort (frame_abort)
    );

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int abort_cnt = 0;

    // count high clk cycles of each pulse output
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one SCLK period: COPI set in low phase, CIPO sampled on the rise
    task automatic send_bit(input logic b, output logic c);
        sif.COPI = b;
        repeat (4) @(negedge clk);
        sif.SCLK = 1'b1;
        c = sif.CIPO;
        repeat (4) @(negedge clk);
        sif.SCLK = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nbits, input int extra,
                             output logic [15:0] cap);
        logic c;
        cap = '0;
        @(negedge clk);
        sif.nCS = 1'b0;
        repeat (6) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            send_bit(w[15-b], c);
            cap[15-b] = c;
        end
        for (int b = 0; b < extra; b++) send_bit(1'b0, c);
        repeat (4) @(negedge clk);
        sif.nCS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        int          extra;
        logic [63:0] exp_regs;
        int          exp_strobes;
        int          exp_aborts;
        logic [6:0]  exp_wr_addr;
        logic [15:0] exp_cipo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] cap;
        logic        c;
        int          s0, a0;

        vecs[0] = '{16'h8455, 16, 0, 64'h0000_0055_0000_0000, 1, 0, 7'd4, 16'h0000};
        vecs[1] = '{16'h0400, 16, 0, 64'h0000_0055_0000_0000, 0, 0, 7'd4, 16'h0055};
        vecs[2] = '{16'h89AA, 16, 0, 64'h0000_0055_0000_0000, 0, 0, 7'd4, 16'h0000};
        vecs[3] = '{16'h0900, 16, 0, 64'h0000_0055_0000_0000, 0, 0, 7'd4, 16'h0000};
        vecs[4] = '{16'h8233, 10, 0, 64'h0000_0055_0000_0000, 0, 1, 7'd4, 16'h0000};
        vecs[5] = '{16'h8233, 16, 0, 64'h0000_0055_0033_0000, 1, 0, 7'd2, 16'h0000};
        vecs[6] = '{16'h8177, 16, 4, 64'h0000_0055_0033_7700, 1, 0, 7'd1, 16'h0000};

        sif.SCLK = 1'b0;
        sif.nCS  = 1'b1;
        sif.COPI = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_regs",    regs_flat, 64'h0);
        check("rst_strobe",  {63'h0, wr_strobe}, 64'h0);
        check("rst_wr_addr", {57'h0, wr_addr}, 64'h0);
        check("rst_abort",   {63'h0, frame_abort}, 64'h0);
        check("rst_cipo",    {63'h0, sif.CIPO}, 64'h0);
        check("rst_oe",      {63'h0, sif.cipo_oe}, 64'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_oe", {63'h0, sif.cipo_oe}, 64'h0);

        for (int v = 0; v < 7; v++) begin
            s0 = strobe_cnt;
            a0 = abort_cnt;
            spi_frame(vecs[v].frame, vecs[v].nbits, vecs[v].extra, cap);
            check($sformatf("v%0d_regs", v),    regs_flat, vecs[v].exp_regs);
            check($sformatf("v%0d_strobes", v), 64'(strobe_cnt - s0), 64'(vecs[v].exp_strobes));
            check($sformatf("v%0d_aborts", v),  64'(abort_cnt - a0), 64'(vecs[v].exp_aborts));
            check($sformatf("v%0d_wr_addr", v), {57'h0, wr_addr}, {57'h0, vecs[v].exp_wr_addr});
            check($sformatf("v%0d_cipo", v),    {48'h0, cap}, {48'h0, vecs[v].exp_cipo});
        end

        // reset in the middle of a write frame
        s0 = strobe_cnt;
        @(negedge clk);
        sif.nCS = 1'b0;
        repeat (6) @(negedge clk);
        check("frame_oe", {63'h0, sif.cipo_oe}, 64'h1);
        for (int b = 0; b < 12; b++) send_bit(b == 0 || b >= 8, c);  // 0x80FF, bits 15..4
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_regs", regs_flat, 64'h0);
        check("midrst_oe",   {63'h0, sif.cipo_oe}, 64'h0);
        rst_n = 1'b1;
        for (int b = 12; b < 16; b++) send_bit(1'b1, c);
        repeat (4) @(negedge clk);
        sif.nCS = 1'b1;
        repeat (8) @(negedge clk);
        check("postrst_regs",    regs_flat, 64'h0);
        check("postrst_strobes", 64'(strobe_cnt - s0), 64'h0);
        check("postrst_wr_addr", {57'h0, wr_addr}, 64'h0);

        s0 = strobe_cnt;
        spi_frame(16'h80FF, 16, 0, cap);
        check("fresh_regs",    regs_flat, 64'h0000_0000_0000_00FF);
        check("fresh_strobes", 64'(strobe_cnt - s0), 64'h1);
        check("fresh_cipo",    {48'h0, cap}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
- Parametrised SPI (mode 0) register-file peripheral. Next generation of the team's write-only SPI control block.
- Adds configurable register count, address width and data width, plus a read path on CIPO, a write strobe and abort detection.
- Sits between the external SPI pins and the PWM/output-enable logic. All SPI inputs are oversampled in the system clock domain.

Parameters:
- NUM_REGS, 8, number of implemented registers at addresses 0..NUM_REGS-1 (1..128).
- ADDR_W, 7, address field width in bits; NUM_REGS must not exceed 2^ADDR_W.
- DATA_W, 8, register and data field width in bits (1..32).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock, asynchronous, idle low.
- nCS  in  1  SPI chip select, asynchronous, active low.
- COPI  in  1  SPI controller-out data, asynchronous.
- CIPO  out  1  SPI peripheral-out data.
- cipo_oe  out  1  CIPO output enable for the pad; equals the inverse of the synchronised nCS.
- regs_flat  out  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse on each committed write.
- wr_addr  out  ADDR_W  address of the last committed write; holds its value between writes.
- frame_abort  out  1  one-clk pulse when a frame ends early.

Behaviour:
- Reset (asynchronous, rst_n low): all registers, CIPO, wr_strobe, wr_addr, frame_abort, shift registers and bit counter go to 0; cipo_oe goes to 0.
  - The synchroniser and previous-value flops for nCS reset to 1; all other synchroniser flops reset to 0.
  - Reset mid-frame discards the frame. The controller must re-assert nCS to start a new frame.
- Synchronisation: SCLK, nCS and COPI each pass through a 2-flop synchroniser.
  - Edges are detected against a third flop (previous value).
  - SCLK rising edge = sample edge; SCLK falling edge = CIPO launch edge.
  - Requirement: SCLK high and low phases each ≥ 3 clk periods.
- Frame format, MSB first, FRAME = 1+ADDR_W+DATA_W bits: bit 1 is R/W (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits.
- States:
  - IDLE: nCS_sync high; nothing is shifted.
  - Falling edge of synchronised nCS → CMD: bit counter and shift register cleared.
  - CMD: each SCLK rise while nCS_sync low shifts in synchronised COPI and increments the counter. When the counter reaches 1+ADDR_W → DATA.
  - DATA: continues shifting. When the counter reaches FRAME → DONE.
  - DONE: further SCLK edges are ignored, and the counter saturates at FRAME. Rising edge of nCS_sync → IDLE.
- Write commit: in the clk cycle after the counter reaches FRAME with R/W=1:
  - if the address is < NUM_REGS, the target register is updated, wr_strobe pulses and wr_addr is loaded;
  - if the address is ≥ NUM_REGS, there is no update and no strobe.
  - Exactly one commit per frame.
- Read: on entering DATA with R/W=0, a DATA_W output shifter is loaded with the addressed register, or 0 if the address is out of range.
  - The value is captured at that instant; later writes do not affect it.
  - CIPO presents the MSB from the first SCLK falling edge after entry into DATA, then shifts one bit per falling edge.
  - CIPO is 0 in IDLE, CMD and DONE, and on writes.
- Abort: rising edge of nCS_sync while the counter is in 1..FRAME-1 → frame_abort pulses for 1 clk. There is no commit and the state returns to IDLE.
  - A rising edge with the counter at 0 or in DONE is not an abort.
- Simultaneous events:
  - An SCLK rise detected in the same clk as the nCS_sync rise is ignored.
  - An nCS falling edge restarts the frame regardless of current state.
- Latency: pin SCLK rise → bit shifted: 3 clk. Final bit shifted → register update: 1 clk.

Test Plan (NUM_REGS=8, ADDR_W=7, DATA_W=8, SCLK = clk/8):
- Write frame 0x8455 → regs_flat[39:32]=0x55; wr_strobe high exactly 1 clk; wr_addr=4; all other registers stay 0.
- After the previous write, read frame 0x0400 → CIPO bits on the 8 data-phase SCLK rises = 0,1,0,1,0,1,0,1; no wr_strobe; reg4 stays 0x55.
- Write frame 0x89AA (address 9, out of range) → no register change, no wr_strobe. Read of address 9 → CIPO all 0.
- Write 0x8233 but raise nCS after 10 bits → frame_abort pulses once; reg2 stays 0; the next full frame 0x8233 sets reg2=0x33.
- Write 0x8177 followed by 4 extra SCLK pulses before nCS rises → reg1=0x77; exactly one wr_strobe; no frame_abort.
- Assert rst_n low after 12 bits of frame 0x80FF, then release → all regs 0; that frame's remaining SCLK pulses cause no commit. A fresh frame 0x80FF → reg0=0xFF.
